// File: rtl/pause_dim_ctrl.sv
// User pause with frame-aligned entry/exit, external pause requests
// and a long-pause screen dimmer on the pixel path.
module pause_dim_ctrl #(
  parameter int NREQ        = 2,
  parameter int RW          = 3,
  parameter int GW          = 3,
  parameter int BW          = 2,
  parameter int DIM_CYCLES  = 480_000_000,
  parameter int DIM_SHIFT   = 1,
  parameter int FRAME_ALIGN = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  pause_btn,
  input  logic [NREQ-1:0]       req,
  input  logic                  vblank,
  input  logic [RW+GW+BW-1:0]   rgb_in,
  output logic [RW+GW+BW-1:0]   rgb_out,
  output logic                  pause,
  output logic                  user_paused,
  output logic                  dimmed
);

  localparam int TW = $clog2(DIM_CYCLES + 1);
  localparam logic [TW-1:0] DIM_MAX = TW'(DIM_CYCLES);
  localparam bit ALIGN = (FRAME_ALIGN != 0);

  typedef enum logic [1:0] {
    RUN,
    PAUSE_PEND,
    PAUSED,
    RESUME_PEND
  } state_t;

  state_t state;
  state_t state_nx;

  logic btn_q;
  logic vb_q;
  logic btn_edge;
  logic vb_edge;
  logic held;

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;

  logic [RW-1:0] r_dim;
  logic [GW-1:0] g_dim;
  logic [BW-1:0] b_dim;

  assign btn_edge = pause_btn & ~btn_q;
  assign vb_edge  = vblank & ~vb_q;
  assign held     = (state == PAUSED) || (state == RESUME_PEND);

  // A button edge always wins, so a coincident vblank edge is ignored.
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: begin
        if (btn_edge) state_nx = ALIGN ? PAUSE_PEND : PAUSED;
      end
      PAUSE_PEND: begin
        if (btn_edge)     state_nx = RUN;
        else if (vb_edge) state_nx = PAUSED;
      end
      PAUSED: begin
        if (btn_edge) state_nx = ALIGN ? RESUME_PEND : RUN;
      end
      RESUME_PEND: begin
        if (btn_edge)     state_nx = PAUSED;
        else if (vb_edge) state_nx = RUN;
      end
    endcase
  end

  always_comb begin
    timer_nx = '0;
    unique case (state)
      PAUSED: begin
        if (timer == DIM_MAX) timer_nx = timer;
        else                  timer_nx = timer + TW'(1);
      end
      RESUME_PEND: timer_nx = timer;
      default:     timer_nx = '0;
    endcase
    // Every fresh entry into PAUSED restarts the dim countdown.
    if (state_nx == PAUSED && state != PAUSED) timer_nx = '0;
  end

  always_comb begin
    r_dim = rgb_in[RW-1:0] >> DIM_SHIFT;
    g_dim = rgb_in[RW +: GW] >> DIM_SHIFT;
    b_dim = rgb_in[RW+GW +: BW] >> DIM_SHIFT;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= RUN;
      timer       <= '0;
      btn_q       <= 1'b1;
      vb_q        <= 1'b1;
      pause       <= 1'b0;
      user_paused <= 1'b0;
      dimmed      <= 1'b0;
      rgb_out     <= '0;
    end else begin
      btn_q       <= pause_btn;
      vb_q        <= vblank;
      state       <= state_nx;
      timer       <= timer_nx;
      pause       <= held | (|req);
      user_paused <= (state_nx == PAUSED) || (state_nx == RESUME_PEND);
      dimmed      <= held && (timer == DIM_MAX);
      rgb_out     <= dimmed ? {b_dim, g_dim, r_dim} : rgb_in;
    end
  end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Randomized bench for pause_dim_ctrl: two instances (frame-aligned
// and immediate) checked every cycle against a want/effective model.
module tb_pause_dim_ctrl;

  localparam int D = 8;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       pause_btn;
  logic       vblank;
  logic [1:0] req;
  logic [7:0] rgb_in;

  logic [7:0] rgb_a, rgb_b;
  logic       pause_a, pause_b;
  logic       up_a, up_b;
  logic       dim_a, dim_b;

  always #5 clk_sys = ~clk_sys;

  pause_dim_ctrl #(
    .DIM_CYCLES (D),
    .DIM_SHIFT  (1),
    .FRAME_ALIGN(1)
  ) u_a (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pause_btn  (pause_btn),
    .req        (req),
    .vblank     (vblank),
    .rgb_in     (rgb_in),
    .rgb_out    (rgb_a),
    .pause      (pause_a),
    .user_paused(up_a),
    .dimmed     (dim_a)
  );

  pause_dim_ctrl #(
    .DIM_CYCLES (D),
    .DIM_SHIFT  (3),
    .FRAME_ALIGN(0)
  ) u_b (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pause_btn  (pause_btn),
    .req        (req),
    .vblank     (vblank),
    .rgb_in     (rgb_in),
    .rgb_out    (rgb_b),
    .pause      (pause_b),
    .user_paused(up_b),
    .dimmed     (dim_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // want: what the user last asked for; eff: what is in force.
  bit m_want[2];
  bit m_eff[2];
  bit m_bp[2];
  bit m_vp[2];
  int m_cnt[2];
  bit e_pause[2];
  bit e_up[2];
  bit e_dim[2];
  int e_rgb[2];
  int sh[2] = '{1, 3};
  bit fa[2] = '{1'b1, 1'b0};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic int dim_px(int px, int s);
    int r, g, b;
    r = px % 8;
    g = (px / 8) % 8;
    b = px / 64;
    return ((b >> s) * 64) + ((g >> s) * 8) + (r >> s);
  endfunction

  task automatic model(int k);
    bit be, ve, was_p;
    if (reset) begin
      m_want[k]  = 0;
      m_eff[k]   = 0;
      m_bp[k]    = 1;
      m_vp[k]    = 1;
      m_cnt[k]   = 0;
      e_pause[k] = 0;
      e_up[k]    = 0;
      e_dim[k]   = 0;
      e_rgb[k]   = 0;
    end else begin
      be = pause_btn && !m_bp[k];
      ve = vblank && !m_vp[k];
      e_rgb[k]   = e_dim[k] ? dim_px(int'(rgb_in), sh[k]) : int'(rgb_in);
      e_pause[k] = m_eff[k] || (req != 2'b00);
      e_dim[k]   = m_eff[k] && (m_cnt[k] == D);
      was_p = m_eff[k] && m_want[k];
      if (was_p) m_cnt[k] = (m_cnt[k] < D) ? m_cnt[k] + 1 : D;
      else if (!m_eff[k]) m_cnt[k] = 0;
      if (be) begin
        m_want[k] = !m_want[k];
        if (!fa[k]) m_eff[k] = m_want[k];
      end else if (ve) begin
        m_eff[k] = m_want[k];
      end
      if (m_eff[k] && m_want[k] && !was_p) m_cnt[k] = 0;
      e_up[k] = m_eff[k];
      m_bp[k] = pause_btn;
      m_vp[k] = vblank;
    end
  endtask

  task automatic cyc();
    model(0);
    model(1);
    @(posedge clk_sys);
    #1;
    chk("a_pause", pause_a, e_pause[0]);
    chk("a_user_paused", up_a, e_up[0]);
    chk("a_dimmed", dim_a, e_dim[0]);
    chk("a_rgb", rgb_a, e_rgb[0]);
    chk("b_pause", pause_b, e_pause[1]);
    chk("b_user_paused", up_b, e_up[1]);
    chk("b_dimmed", dim_b, e_dim[1]);
    chk("b_rgb", rgb_b, e_rgb[1]);
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    cyc();
    vblank = 1'b0;
  endtask

  task automatic press();
    pause_btn = 1'b1;
    cyc();
    pause_btn = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    pause_btn = 1'b0;
    vblank    = 1'b0;
    req       = 2'b00;
    rgb_in    = 8'h00;
    repeat (2) cyc();
    reset = 1'b0;

    // Aligned pause entry, then dimming of a full-white pixel.
    repeat (8) cyc();
    press();
    repeat (38) cyc();
    vb_pulse();
    rgb_in = 8'hFF;
    repeat (12) cyc();
    chk("dim_reached", dim_a, 1'b1);
    chk("rgb_5b", rgb_a, 8'h5B);
    chk("rgb_b_zero", rgb_b, 8'h00);

    // Aligned resume.
    press();
    repeat (3) cyc();
    vb_pulse();
    repeat (3) cyc();
    chk("resumed", up_a, 1'b0);

    // Cancel a pending pause.
    press();
    cyc();
    press();
    repeat (4) cyc();

    // External request pulse.
    req = 2'b10;
    repeat (5) cyc();
    req = 2'b00;
    repeat (3) cyc();

    // Button and vblank edges together.
    pause_btn = 1'b1;
    vblank    = 1'b1;
    cyc();
    pause_btn = 1'b0;
    vblank    = 1'b0;
    repeat (3) cyc();
    vb_pulse();
    repeat (2) cyc();
    pause_btn = 1'b1;
    vblank    = 1'b1;
    cyc();
    pause_btn = 1'b0;
    vblank    = 1'b0;
    repeat (3) cyc();
    vb_pulse();
    repeat (2) cyc();

    // Reset mid-pause with the button held through release.
    press();
    vb_pulse();
    repeat (4) cyc();
    reset     = 1'b1;
    pause_btn = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (4) cyc();
    chk("held_btn_no_toggle", up_b, 1'b0);
    pause_btn = 1'b0;
    cyc();
    press();
    repeat (3) cyc();
    vb_pulse();
    repeat (2) cyc();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) pause_btn = ~pause_btn;
      vblank = ($urandom_range(0, 15) == 0);
      req    = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      rgb_in = 8'($urandom);
      reset  = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
